// File: rtl/xoroshiro_pkg.sv
// Shared xoroshiro128 definitions: default seed, rotate/shift constants and the
// state-update and byte-lane output functions used by generator and checker.
package xoroshiro_pkg;

    localparam logic [127:0] DEFAULT_SEED = 128'hA57AFD30D24E7488_24C9E7755DED7017;

    localparam int unsigned ROT_A   = 55;
    localparam int unsigned SHIFT_B = 14;
    localparam int unsigned ROT_C   = 36;

    typedef enum logic {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned k);
        return (x << k) | (x >> (64 - k));
    endfunction

    // Lanes are added independently: each byte wraps mod 256, no carry across lanes.
    function automatic logic [7:0] lane_byte(input logic [63:0] s0,
                                             input logic [63:0] s1,
                                             input logic [2:0]  idx);
        int unsigned base;
        base = 63 - 8 * int'(idx);
        return s0[base -: 8] + s1[base -: 8];
    endfunction

    function automatic logic [63:0] next_s0(input logic [63:0] s0, input logic [63:0] s1);
        logic [63:0] t;
        t = s0 ^ s1;
        return rotl(s0, ROT_A) ^ t ^ (t << SHIFT_B);
    endfunction

    function automatic logic [63:0] next_s1(input logic [63:0] s0, input logic [63:0] s1);
        return rotl(s0 ^ s1, ROT_C);
    endfunction

endpackage

// File: rtl/xoroshiro128_stream_checker_if.sv
// Byte-stream input and status bundle of the xoroshiro128 stream checker.
interface xoroshiro128_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [7:0]       data_in;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    modport master (
        output en, data_in,
        input  locked, err, err_count, word_count
    );

    modport slave (
        input  en, data_in,
        output locked, err, err_count, word_count
    );
endinterface

// File: rtl/xoroshiro128_core.sv
// Local xoroshiro128 generator: s0/s1 state plus byte index, producing the
// expected byte for the current lane.
module xoroshiro128_core
    import xoroshiro_pkg::*;
#(
    parameter logic [127:0] SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       reload,
    output logic [7:0] exp,
    output logic       last
);

    logic [63:0] s0;
    logic [63:0] s1;
    logic [2:0]  idx;

    // The word update lands in the same cycle as the idx=7 byte, so streams run gap-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0  <= SEED[127:64];
            s1  <= SEED[63:0];
            idx <= 3'd0;
        end else if (reload) begin
            s0  <= SEED[127:64];
            s1  <= SEED[63:0];
            idx <= 3'd0;
        end else if (advance) begin
            if (idx == 3'd7) begin
                s0 <= next_s0(s0, s1);
                s1 <= next_s1(s0, s1);
            end
            idx <= idx + 3'd1;
        end
    end

    assign exp  = lane_byte(s0, s1, idx);
    assign last = (idx == 3'd7);

endmodule

// File: rtl/xoroshiro128_stream_checker.sv
// Receive-side checker for the xoroshiro128 byte stream: hunts for the first
// byte, then tracks errors, lock and completed words.
module xoroshiro128_stream_checker
    import xoroshiro_pkg::*;
#(
    parameter logic [127:0] SEED       = DEFAULT_SEED,
    parameter int           CNT_W      = 16,
    parameter int           LOSS_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    xoroshiro128_stream_checker_if.slave bus
);

    localparam int MISS_W = $clog2(LOSS_LIMIT + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_LIMIT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_e        state;
    chk_state_e        state_nx;
    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] miss_nx;
    logic              err;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_count;

    logic       advance;
    logic       reload;
    logic       err_set;
    logic       word_inc;
    logic       lose;
    logic       match;
    logic [7:0] exp;
    logic       last;

    xoroshiro128_core #(
        .SEED (SEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .reload  (reload),
        .exp     (exp),
        .last    (last)
    );

    assign match = (bus.data_in == exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            miss  <= '0;
        end else begin
            state <= state_nx;
            miss  <= miss_nx;
        end
    end

    // clr outranks en: the sample presented alongside clr is dropped.
    always_comb begin
        state_nx = state;
        miss_nx  = miss;
        advance  = 1'b0;
        reload   = 1'b0;
        err_set  = 1'b0;
        word_inc = 1'b0;
        lose     = 1'b0;
        if (clr) begin
            state_nx = HUNT;
            miss_nx  = '0;
            reload   = 1'b1;
        end else if (bus.en) begin
            case (state)
                HUNT: begin
                    if (match) begin
                        state_nx = CHECK;
                        advance  = 1'b1;
                    end
                end
                CHECK: begin
                    word_inc = last;
                    if (match) begin
                        miss_nx = '0;
                    end else begin
                        err_set = 1'b1;
                        if (miss == MISS_LAST) begin
                            lose = 1'b1;
                        end else begin
                            miss_nx = miss + MISS_W'(1);
                        end
                    end
                    // A run of LOSS_LIMIT misses means we are misaligned: restart the hunt.
                    if (lose) begin
                        state_nx = HUNT;
                        miss_nx  = '0;
                        reload   = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_nx = HUNT;
                    reload   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else if (clr) begin
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (err_set) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_count);
            end
            if (word_inc) begin
                word_count <= sat_inc(word_count);
            end
        end
    end

    assign bus.locked     = (state == CHECK);
    assign bus.err        = err;
    assign bus.err_count  = err_count;
    assign bus.word_count = word_count;

endmodule
